// File: rtl/bcd_digit_source.sv
// Multi-digit BCD up/down counter with a snapshot digit scanner (valid/ready, LSD first).
// Build option: define BCD_SAT_EN to saturate at all-9s / all-0s instead of wrapping.
//
// state | meaning
// IDLE  | no digit stream; waiting for snap to capture count into shadow
// SCAN  | presenting shadow digits one per handshake, index 0 upward
module bcd_digit_source #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    snap,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    carry,
  output logic                    dig_valid,
  input  logic                    dig_ready,
  output logic [3:0]              dig,
  output logic [2:0]              dig_idx,
  output logic                    busy
);

  localparam int W = 4 * NUM_DIGITS;
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t       state;
  logic [W-1:0] step_val;
  logic [W-1:0] load_clamped;
  logic [W-1:0] shadow;
  logic [W-1:0] shadow_next;
  logic         ripple;
  logic         wrap;

  // Ripple a +1 / -1 through the digits; a ripple out of the top digit is a wrap.
  always_comb begin
    step_val = count;
    ripple   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ripple) begin
        if (up) begin
          if (count[4*i +: 4] == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (count[4*i +: 4] == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
            ripple = 1'b0;
          end
        end
      end
    end
    wrap = ripple;
  end

  always_comb begin
    load_clamped = load_val;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_clamped[4*i +: 4] = 4'd9;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      carry <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      carry <= 1'b0;
    end else if (en) begin
`ifdef BCD_SAT_EN
      if (!wrap) count <= step_val;
      carry <= wrap;
`else
      count <= step_val;
      carry <= wrap;
`endif
    end else begin
      carry <= 1'b0;
    end
  end

  // The shadow shifts down one digit per accepted handshake, so dig is always its low nibble.
  assign shadow_next = shadow >> 4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      dig       <= 4'd0;
      dig_idx   <= 3'd0;
      dig_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (snap) begin
            shadow    <= count;
            dig       <= count[3:0];
            dig_idx   <= 3'd0;
            dig_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (dig_ready) begin
            if (dig_idx == LAST_IDX) begin
              dig_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              shadow  <= shadow_next;
              dig     <= shadow_next[3:0];
              dig_idx <= dig_idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_digit_source.sv
// Testbench for bcd_digit_source: directed steps plus randomized traffic against
// an integer-valued reference model of the counter and the snapshot stream.
module tb_bcd_digit_source;
  localparam int N   = 4;
  localparam int MAX = 9999;

  logic        clk = 1'b0;
  logic        rst, en, up, load, snap, dig_ready;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        carry, dig_valid, busy;
  logic [3:0]  dig;
  logic [2:0]  dig_idx;

  int checks = 0;
  int errors = 0;

  int m_val, m_carry, m_busy, m_idx, m_dig, m_snap;

  always #5 clk = ~clk;

  bcd_digit_source #(.NUM_DIGITS(N)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .snap(snap), .count(count), .carry(carry), .dig_valid(dig_valid),
    .dig_ready(dig_ready), .dig(dig), .dig_idx(dig_idx), .busy(busy)
  );

  function automatic int pow10(int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r = '0;
    for (int i = 0; i < N; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int clamp_val(logic [15:0] lv);
    int v = 0;
    int d;
    for (int i = 0; i < N; i++) begin
      d = int'({28'd0, lv[4*i +: 4]});
      if (d > 9) d = 9;
      v = v + d * pow10(i);
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_idx = 0; m_dig = 0;
    end else if (m_busy == 0) begin
      if (snap) begin
        m_snap = m_val; m_busy = 1; m_idx = 0; m_dig = m_snap % 10;
      end
    end else if (dig_ready) begin
      if (m_idx == N - 1) m_busy = 0;
      else begin
        m_idx++;
        m_dig = (m_snap / pow10(m_idx)) % 10;
      end
    end

    if (rst) begin
      m_val = 0; m_carry = 0;
    end else if (load) begin
      m_val = clamp_val(load_val); m_carry = 0;
    end else if (en) begin
      if (up) begin
        if (m_val == MAX) begin
          m_carry = 1;
`ifndef BCD_SAT_EN
          m_val = 0;
`endif
        end else begin
          m_val++; m_carry = 0;
        end
      end else begin
        if (m_val == 0) begin
          m_carry = 1;
`ifndef BCD_SAT_EN
          m_val = MAX;
`endif
        end else begin
          m_val--; m_carry = 0;
        end
      end
    end else begin
      m_carry = 0;
    end

    #1;
    chk("count", 32'(count), 32'(to_bcd(m_val)));
    chk("carry", 32'(carry), 32'(m_carry));
    chk("dig_valid", 32'(dig_valid), 32'(m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    if (m_busy != 0 || rst) begin
      chk("dig", 32'(dig), 32'(m_dig));
      chk("dig_idx", 32'(dig_idx), 32'(m_idx));
    end
  endtask

  initial begin
    int bound;
    int sel;
    m_val = 0; m_carry = 0; m_busy = 0; m_idx = 0; m_dig = 0; m_snap = 0;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    snap = 1'b0; dig_ready = 1'b0;
    tick();
    tick();

    // Count up 12 steps from zero.
    rst = 1'b0; en = 1'b1; up = 1'b1;
    repeat (12) tick();
    chk("count_after_12", 32'(count), 32'h0012);

    // Wrap up from all-9s, then wrap down from all-0s.
    en = 1'b0; load = 1'b1; load_val = 16'h9999;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    en = 1'b0;
    tick();
    load = 1'b1; load_val = 16'h0000;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    en = 1'b0;

    // Nibbles above 9 clamp on load.
    load = 1'b1; load_val = 16'h3A7F;
    tick();
    chk("load_clamp", 32'(count), 32'h3979);

    // Full-speed scan of 1234.
    load_val = 16'h1234;
    tick();
    load = 1'b0; snap = 1'b1; dig_ready = 1'b1;
    tick();
    snap = 1'b0;
    repeat (6) tick();

    // Scan with a randomly toggling consumer.
    load = 1'b1; load_val = 16'h8705;
    tick();
    load = 1'b0; snap = 1'b1;
    tick();
    snap = 1'b0;
    bound = 0;
    while (m_busy != 0 && bound < 60) begin
      dig_ready = 1'($urandom_range(0, 1));
      tick();
      bound++;
    end
    chk("scan_toggle_done", 32'(m_busy), 32'd0);

    // snap held during the scan while the counter runs.
    load = 1'b1; load_val = 16'h4560;
    tick();
    load = 1'b0; snap = 1'b1; dig_ready = 1'b1; en = 1'b1; up = 1'($urandom_range(0, 1));
    repeat (4) tick();
    snap = 1'b0;
    repeat (3) tick();
    en = 1'b0;

    // Reset in the middle of a scan at index 2.
    load = 1'b1; load_val = 16'h4321;
    tick();
    load = 1'b0; snap = 1'b1; dig_ready = 1'b1;
    tick();
    snap = 1'b0;
    bound = 0;
    while (m_idx != 2 && bound < 10) begin
      tick();
      bound++;
    end
    chk("reached_idx2", 32'(dig_idx), 32'd2);
    rst = 1'b1;
    tick();
    chk("rst_mid_scan_valid", 32'(dig_valid), 32'd0);
    chk("rst_mid_scan_count", 32'(count), 32'd0);
    rst = 1'b0;
    tick();

    // Randomized traffic.
    repeat (600) begin
      rst  = ($urandom_range(0, 99) == 0);
      load = ($urandom_range(0, 15) == 0);
      sel  = $urandom_range(0, 3);
      if (sel == 0)      load_val = 16'h9999;
      else if (sel == 1) load_val = 16'h0000;
      else               load_val = 16'($urandom);
      en        = 1'($urandom_range(0, 1));
      up        = 1'($urandom_range(0, 1));
      snap      = ($urandom_range(0, 3) == 0);
      dig_ready = 1'($urandom_range(0, 1));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
